gt_reset_sequencer: RTL



---
 rtl/gt_reset_pkg.sv | 40 ++++
 rtl/gt_lane_rx_restart.sv | 49 ++++
 rtl/gt_reset_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gt_reset_pkg.sv
// Shared types and helpers for the GT/QPLL reset sequencer.
// Holds the sequencer state encoding and the width helpers that size the
// shared phase timer and the retry counter from the top-level parameters.
package gt_reset_pkg;

  // Sequencer states, in the order a healthy bring-up walks through them.
  typedef enum logic [2:0] {
    HOLDOFF   = 3'd0,
    QPLL_RST  = 3'd1,
    WAIT_LOCK = 3'd2,
    GT_RST    = 3'd3,
    WAIT_DONE = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } gt_state_t;

  localparam int STATE_W = 3;

  // Width of the single down-counter shared by all timed states: wide enough
  // for the longest duration it ever has to hold, plus one bit of headroom.
  function automatic int timer_width(input int holdoff_cycles,
                                     input int lock_timeout_cycles,
                                     input int done_timeout_cycles,
                                     input int pulse_cycles);
    int longest;
    longest = holdoff_cycles;
    if (lock_timeout_cycles > longest) longest = lock_timeout_cycles;
    if (done_timeout_cycles > longest) longest = done_timeout_cycles;
    if (pulse_cycles > longest) longest = pulse_cycles;
    return $clog2(longest) + 1;
  endfunction

  // Width of the retry counter; never narrower than one bit so a design
  // built with no retries still has a legal port.
  function automatic int retry_width(input int max_retries);
    if (max_retries < 1) return 1;
    return $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/gt_lane_rx_restart.sv
// Per-lane RX re-reset pulse generator.
// While enabled (sequencer sitting in READY), a single-cycle restart request
// starts a PULSE_CYCLES long GT RX reset on this lane and drops the lane's
// RX user-ready for the same cycles. A request during a running pulse starts
// the count again. Dropping the enable aborts the pulse immediately.
// The override outputs are next-cycle values; the top registers them
// together with its other outputs so every pin leaves a flop.
module gt_lane_rx_restart #(
  parameter int PULSE_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic rxreset_ovr_o,
  output logic rxuserrdy_drop_o
);

  localparam int LW = $clog2(PULSE_CYCLES + 1);
  localparam logic [LW-1:0] PULSE_LD = LW'(PULSE_CYCLES);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  // Remaining pulse cycles: reload on request, count down, clear when disabled.
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      if (restart_i) begin
        cnt_d = PULSE_LD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Pulse counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rxreset_ovr_o    = (cnt_d != '0);
  assign rxuserrdy_drop_o = (cnt_d != '0);

endmodule

// File: rtl/gt_reset_sequencer.sv
// Multi-lane GT/QPLL reset sequencer for the 10G PHY (156.25 MHz domain).
// Sequence: post-configuration hold-off, QPLL reset pulse, wait for QPLL lock
// (with timeout and bounded retry), GT TX/RX reset pulse on all lanes, wait
// for every lane's reset-done, then READY. In READY each lane can be given an
// independent RX re-reset pulse.
//
// Build option GT_RESET_LOCK_MONITOR_EN:
//   defined   - losing qplllock_i in READY restarts from the QPLL reset with a
//               fresh retry budget.
//   undefined - READY ignores qplllock_i and is left only through rst_i.
//
// All outputs come straight from flops. They are loaded from the next-state
// decode, so each output shows the value belonging to the state the
// sequencer occupies in that cycle.
module gt_reset_sequencer
  import gt_reset_pkg::*;
#(
  parameter int NUM_LANES           = 8,
  parameter int HOLDOFF_CYCLES      = 128,
  parameter int PULSE_CYCLES        = 3,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int DONE_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   qplllock_i,
  input  logic [NUM_LANES-1:0]                   txresetdone_i,
  input  logic [NUM_LANES-1:0]                   rxresetdone_i,
  input  logic [NUM_LANES-1:0]                   rx_restart_i,
  output logic                                   qpllreset_o,
  output logic [NUM_LANES-1:0]                   gttxreset_o,
  output logic [NUM_LANES-1:0]                   gtrxreset_o,
  output logic [NUM_LANES-1:0]                   txuserrdy_o,
  output logic [NUM_LANES-1:0]                   rxuserrdy_o,
  output logic                                   ready_o,
  output logic                                   fail_o,
  output logic [retry_width(MAX_RETRIES)-1:0]    retry_cnt_o,
  output logic [STATE_W-1:0]                     dbg_state_o
);

  localparam int CNT_W = timer_width(HOLDOFF_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     DONE_TIMEOUT_CYCLES, PULSE_CYCLES);
  localparam int RW    = retry_width(MAX_RETRIES);

  // Timer reload values: the counter expires when it reaches zero, so a
  // state lasting N cycles is entered with N-1.
  localparam logic [CNT_W-1:0] LD_HOLDOFF = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LOCK    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_DONE    = CNT_W'(DONE_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRIES);

  gt_state_t             state_q;
  gt_state_t             state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [RW-1:0]         retry_q;
  logic [RW-1:0]         retry_d;
  logic                  expired;
  logic                  retry_req;
  logic                  all_done;
  logic                  lane_en;
  logic [NUM_LANES-1:0]  lane_rst_d;
  logic [NUM_LANES-1:0]  lane_drop_d;

  // Next-cycle output values, decoded from the next state.
  logic                  qpllreset_d;
  logic                  gt_all_d;
  logic                  userrdy_d;
  logic [NUM_LANES-1:0]  gttxreset_d;
  logic [NUM_LANES-1:0]  gtrxreset_d;
  logic [NUM_LANES-1:0]  txuserrdy_d;
  logic [NUM_LANES-1:0]  rxuserrdy_d;
  logic                  ready_d;
  logic                  fail_d;

  // Duration loaded into the shared timer when a state is entered.
  function automatic logic [CNT_W-1:0] load_for(input gt_state_t s);
    logic [CNT_W-1:0] v;
    v = '0;
    unique case (s)
      HOLDOFF:   v = LD_HOLDOFF;
      QPLL_RST:  v = LD_PULSE;
      WAIT_LOCK: v = LD_LOCK;
      GT_RST:    v = LD_PULSE;
      WAIT_DONE: v = LD_DONE;
      default:   v = '0;
    endcase
    return v;
  endfunction

  assign expired  = (cnt_q == '0);
  assign all_done = (&txresetdone_i) & (&rxresetdone_i);

  // Next-state, timer and retry-budget decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    retry_req = 1'b0;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    unique case (state_q)
      HOLDOFF: begin
        if (expired) state_d = QPLL_RST;
      end
      QPLL_RST: begin
        if (expired) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is checked first so a lock arriving on the last timeout
        // cycle still counts as success.
        if (qplllock_i) begin
          state_d = GT_RST;
        end else if (expired) begin
          retry_req = 1'b1;
        end
      end
      GT_RST: begin
        if (expired) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A QPLL that drops lock invalidates the GT resets in flight.
        if (!qplllock_i) begin
          retry_req = 1'b1;
        end else if (all_done) begin
          state_d = READY;
        end else if (expired) begin
          retry_req = 1'b1;
        end
      end
      READY: begin
`ifdef GT_RESET_LOCK_MONITOR_EN
        if (!qplllock_i) begin
          state_d = QPLL_RST;
          retry_d = '0;
        end
`endif
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = HOLDOFF;
      end
    endcase

    // Shared retry path: re-run the QPLL reset while budget remains.
    if (retry_req) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = QPLL_RST;
      end else begin
        state_d = FAIL;
      end
    end

    if (state_d != state_q) begin
      cnt_d = load_for(state_d);
    end
  end

  // Lanes accept restarts only while the sequencer is in READY and stays
  // there; any exit from READY clears every lane pulse.
  assign lane_en = (state_q == READY) && (state_d == READY);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gt_lane_rx_restart #(
      .PULSE_CYCLES (PULSE_CYCLES)
    ) u_lane (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .en_i             (lane_en),
      .restart_i        (rx_restart_i[g]),
      .rxreset_ovr_o    (lane_rst_d[g]),
      .rxuserrdy_drop_o (lane_drop_d[g])
    );
  end

  // Output decode from the next state plus the per-lane overrides.
  always_comb begin
    qpllreset_d = (state_d == HOLDOFF) || (state_d == QPLL_RST) || (state_d == FAIL);
    gt_all_d    = (state_d == HOLDOFF) || (state_d == QPLL_RST) ||
                  (state_d == WAIT_LOCK) || (state_d == GT_RST) || (state_d == FAIL);
    userrdy_d   = (state_d == WAIT_DONE) || (state_d == READY);
    gttxreset_d = {NUM_LANES{gt_all_d}};
    gtrxreset_d = {NUM_LANES{gt_all_d}} | lane_rst_d;
    txuserrdy_d = {NUM_LANES{userrdy_d}};
    rxuserrdy_d = {NUM_LANES{userrdy_d}} & ~lane_drop_d;
    ready_d     = (state_d == READY);
    fail_d      = (state_d == FAIL);
  end

  // State, timer, retry budget and all output flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HOLDOFF;
      cnt_q       <= LD_HOLDOFF;
      retry_q     <= '0;
      qpllreset_o <= 1'b1;
      gttxreset_o <= '1;
      gtrxreset_o <= '1;
      txuserrdy_o <= '0;
      rxuserrdy_o <= '0;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      qpllreset_o <= qpllreset_d;
      gttxreset_o <= gttxreset_d;
      gtrxreset_o <= gtrxreset_d;
      txuserrdy_o <= txuserrdy_d;
      rxuserrdy_o <= rxuserrdy_d;
      ready_o     <= ready_d;
      fail_o      <= fail_d;
    end
  end

  assign retry_cnt_o = retry_q;
  assign dbg_state_o = state_q;

endmodule
